// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
// Holds the FSM state enum and the counter width constants.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    HOLD,
    RELEASE,
    RUN,
    ASSERT
  } rst_state_e;

  localparam int LLC_W = 8;

  function automatic int cnt_width(input int lf, input int sc);
    int m;
    m = (lf > sc) ? lf : sc;
    return $clog2(m + 1);
  endfunction

  localparam int CNT_W = cnt_width(8, 16);

endpackage

// File: rtl/rst_seq_sync.sv
// Multi-flop synchroniser for an asynchronous level input.
// Ports: clk_i, rst_ni (async clear), d_i (async in), q_o (synced out).
module rst_seq_sync
  import rst_seq_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *)
  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq_xil7series.sv
// Reset sequencer following a 7-series PLL: filters LOCKED, then
// releases NUM_RST active-low resets in order; counts lock losses.
// Ports: IO_CLK, IO_RST_N, pll_locked, sw_rst_req -> rst_n_o,
//        seq_done, lock_loss_cnt.
module rst_seq_xil7series
  import rst_seq_pkg::*;
#(
  parameter int NUM_RST      = 3,
  parameter int STAGE_CYCLES = 16,
  parameter int LOCK_FILTER  = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic               IO_CLK,
  input  logic               IO_RST_N,
  input  logic               pll_locked,
  input  logic               sw_rst_req,
  output logic [NUM_RST-1:0] rst_n_o,
  output logic               seq_done,
  output logic [LLC_W-1:0]   lock_loss_cnt
);

  localparam int CW = cnt_width(LOCK_FILTER, STAGE_CYCLES);
  localparam logic [CW-1:0] LF_M1 = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] SC_M1 = CW'(STAGE_CYCLES - 1);

  logic               lock_s;
  rst_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_RST-1:0] rst_q, rst_d;
  logic               done_q, done_d;
  logic [LLC_W-1:0]   llc_q, llc_d;
  logic               start_rel;

  rst_seq_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i  (IO_CLK),
    .rst_ni (IO_RST_N),
    .d_i    (pll_locked),
    .q_o    (lock_s)
  );

  // One counter serves the lock filter, the stage spacing and the
  // software-reset hold; only one of these is active per state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rst_d     = rst_q;
    done_d    = done_q;
    llc_d     = llc_q;
    start_rel = 1'b0;

    unique case (state_q)
      WAIT_LOCK: begin
        rst_d  = '0;
        done_d = 1'b0;
        cnt_d  = '0;
        if (lock_s) begin
          if (LOCK_FILTER == 1) begin
            start_rel = 1'b1;
          end else begin
            state_d = HOLD;
            cnt_d   = CW'(1);
          end
        end
      end

      HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == LF_M1) begin
          start_rel = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      RELEASE, RUN: begin
        if (!lock_s) begin
          // Lock loss outranks a coincident software request.
          state_d = WAIT_LOCK;
          rst_d   = '0;
          done_d  = 1'b0;
          cnt_d   = '0;
          if (llc_q != '1) llc_d = llc_q + LLC_W'(1);
        end else if (sw_rst_req) begin
          state_d = ASSERT;
          rst_d   = '0;
          done_d  = 1'b0;
          cnt_d   = '0;
        end else if (state_q == RELEASE) begin
          if (cnt_q == SC_M1) begin
            cnt_d = '0;
            // Shift a one in from bit 0 so release stays in order.
            rst_d = NUM_RST'({rst_q, 1'b1});
            if (&rst_d) begin
              state_d = RUN;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      ASSERT: begin
        rst_d  = '0;
        done_d = 1'b0;
        if (cnt_q == SC_M1) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = WAIT_LOCK;
        rst_d   = '0;
        done_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase

    if (start_rel) begin
      rst_d = NUM_RST'(1);
      cnt_d = '0;
      if (NUM_RST == 1) begin
        state_d = RUN;
        done_d  = 1'b1;
      end else begin
        state_d = RELEASE;
      end
    end
  end

  always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
    if (!IO_RST_N) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
      llc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      llc_q   <= llc_d;
    end
  end

  assign rst_n_o       = rst_q;
  assign seq_done      = done_q;
  assign lock_loss_cnt = llc_q;

endmodule
